// File: rtl/rcu_sched_arbiter.sv
// Scheduler for the RCU reader/updater model: picks one process per enabled edge
// from a Galois LFSR, with a per-process age bound that forces starved processes.
module rcu_sched_arbiter #(
   parameter int          NRDR         = 4,
   parameter int          SELMSB       = 2,
   parameter int          STARVE_LIMIT = 12,
   parameter int          AGE_W        = 4,
   parameter logic [15:0] SEED_DEF     = 16'hACE1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              en,
   input  logic [NRDR:0]     mask,
   input  logic              seed_load,
   input  logic [15:0]       seed,
   output logic [SELMSB:0]   select,
   output logic              sel_valid,
   output logic              forced,
   output logic [15:0]       grant_cnt
);

   localparam int               NPROC     = NRDR + 1;
   localparam int               SW        = SELMSB + 1;
   localparam logic [SW:0]      NPROC_W   = (SW+1)'(NPROC);
   localparam logic [AGE_W-1:0] AGE_LIMIT = AGE_W'(STARVE_LIMIT);

   logic [15:0]       lfsr_reg;
   logic [15:0]       lfsr_next;
   logic [SW-1:0]     select_reg;
   logic              sel_valid_reg;
   logic              forced_reg;
   logic [15:0]       grant_cnt_reg;
   logic [AGE_W-1:0]  age_reg [NPROC];

   logic [SW-1:0]     raw;
   logic [SW-1:0]     cand;
   logic [NPROC-1:0]  expired;
   logic              exp_hit;
   logic [SW-1:0]     exp_idx;
   logic              scan_hit;
   logic [SW-1:0]     scan_idx;
   logic [SW:0]       scan_pos;
   logic              grant_hit;
   logic [SW-1:0]     winner;
   logic              advance;

   assign advance   = en && !seed_load;
   assign lfsr_next = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

   // Fold the raw LFSR slice into 0..NPROC-1; one subtraction suffices since 2^SW <= 2*NPROC.
   assign raw  = lfsr_reg[SELMSB:0];
   assign cand = ({1'b0, raw} >= NPROC_W) ? SW'({1'b0, raw} - NPROC_W) : raw;

   genvar gi;
   generate
      for (gi = 0; gi < NPROC; gi++) begin : g_expired
         assign expired[gi] = !mask[gi] && (age_reg[gi] == AGE_LIMIT);
      end
   endgenerate

   // Descending loops so the lowest index / nearest offset is assigned last and wins.
   always_comb begin
      exp_hit  = 1'b0;
      exp_idx  = '0;
      scan_hit = 1'b0;
      scan_idx = '0;
      scan_pos = '0;
      for (int k = NPROC - 1; k >= 0; k--) begin
         if (expired[k]) begin
            exp_hit = 1'b1;
            exp_idx = SW'(k);
         end
      end
      for (int k = NPROC - 1; k >= 0; k--) begin
         scan_pos = {1'b0, cand} + (SW+1)'(k);
         if (scan_pos >= NPROC_W) begin
            scan_pos = scan_pos - NPROC_W;
         end
         if (!mask[scan_pos]) begin
            scan_hit = 1'b1;
            scan_idx = SW'(scan_pos);
         end
      end
      grant_hit = exp_hit || scan_hit;
      winner    = exp_hit ? exp_idx : scan_idx;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_reg      <= SEED_DEF;
         select_reg    <= '0;
         sel_valid_reg <= 1'b0;
         forced_reg    <= 1'b0;
         grant_cnt_reg <= '0;
      end else if (seed_load) begin
         lfsr_reg      <= (seed == 16'h0000) ? SEED_DEF : seed;
         sel_valid_reg <= 1'b0;
         forced_reg    <= 1'b0;
      end else if (!en) begin
         sel_valid_reg <= 1'b0;
         forced_reg    <= 1'b0;
      end else begin
         lfsr_reg <= lfsr_next;
         if (grant_hit) begin
            select_reg    <= winner;
            sel_valid_reg <= 1'b1;
            forced_reg    <= exp_hit;
            if (grant_cnt_reg != 16'hFFFF) begin
               grant_cnt_reg <= grant_cnt_reg + 16'd1;
            end
         end else begin
            sel_valid_reg <= 1'b0;
            forced_reg    <= 1'b0;
         end
      end
   end

   // Ages saturate at the limit so an expired process stays expired until granted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < NPROC; p++) begin
            age_reg[p] <= '0;
         end
      end else if (advance && grant_hit) begin
         for (int p = 0; p < NPROC; p++) begin
            if (winner == SW'(p)) begin
               age_reg[p] <= '0;
            end else if (!mask[p] && (age_reg[p] != AGE_LIMIT)) begin
               age_reg[p] <= age_reg[p] + 1'b1;
            end
         end
      end
   end

   assign select    = select_reg;
   assign sel_valid = sel_valid_reg;
   assign forced    = forced_reg;
   assign grant_cnt = grant_cnt_reg;

endmodule

// File: tb/tb_rcu_sched_arbiter.sv
// Directed and randomised checks for rcu_sched_arbiter: LFSR sequence, masking,
// seeding, starvation override, async reset and grant counting.
module tb_rcu_sched_arbiter;

   logic        clock;
   logic        reset_n;
   logic        en;
   logic [4:0]  mask;
   logic        seed_load;
   logic [15:0] seed;
   logic [2:0]  select;
   logic        sel_valid;
   logic        forced;
   logic [15:0] grant_cnt;

   int vectors = 0;
   int errors  = 0;
   int skip [5];
   int grants  = 0;

   rcu_sched_arbiter dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .en        (en),
      .mask      (mask),
      .seed_load (seed_load),
      .seed      (seed),
      .select    (select),
      .sel_valid (sel_valid),
      .forced    (forced),
      .grant_cnt (grant_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      en        = 1'b0;
      seed_load = 1'b0;
      seed      = 16'h0000;
      mask      = 5'b00000;
      reset_n   = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      for (int p = 0; p < 5; p++) skip[p] = 0;
      grants = 0;
   endtask

   // Expected starvation override: lowest unmasked process passed over 12 times.
   function automatic void exp_force(input logic [4:0] m, output bit hit, output int idx);
      hit = 1'b0;
      idx = 0;
      for (int p = 4; p >= 0; p--) begin
         if (!m[p] && skip[p] >= 12) begin
            hit = 1'b1;
            idx = p;
         end
      end
   endfunction

   task automatic model_update(input logic [4:0] m);
      if (sel_valid === 1'b1) begin
         grants++;
         for (int p = 0; p < 5; p++) begin
            if (p == int'(select)) skip[p] = 0;
            else if (!m[p]) skip[p]++;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if (select !== 3'd0 || sel_valid !== 1'b0 || forced !== 1'b0 || grant_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: got sel=%0d v=%0b f=%0b cnt=%0d, want 0/0/0/0",
                  select, sel_valid, forced, grant_cnt);
      end
   endtask

   task automatic test_lfsr_sequence();
      logic [2:0] exp_sel [4];
      exp_sel[0] = 3'd1; exp_sel[1] = 3'd0; exp_sel[2] = 3'd0; exp_sel[3] = 3'd4;
      apply_reset();
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         $display("txn seq edge=%0d select=%0d valid=%0b forced=%0b", i, select, sel_valid, forced);
         vectors++;
         if (select !== exp_sel[i] || sel_valid !== 1'b1 || forced !== 1'b0) begin
            errors++;
            $display("FAIL seq_edge%0d: got sel=%0d v=%0b f=%0b, want sel=%0d v=1 f=0",
                     i, select, sel_valid, forced, exp_sel[i]);
         end
      end
      vectors++;
      if (grant_cnt !== 16'd4) begin
         errors++;
         $display("FAIL seq_grant_cnt: got %0d, want 4", grant_cnt);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      en = 1'b1;
      step();
      step();
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (select !== 3'd0 || sel_valid !== 1'b0 || forced !== 1'b0 || grant_cnt !== 16'd0) begin
         errors++;
         $display("FAIL async_reset: got sel=%0d v=%0b f=%0b cnt=%0d, want 0/0/0/0",
                  select, sel_valid, forced, grant_cnt);
      end
      step();
      reset_n = 1'b1;
      en = 1'b0;
   endtask

   task automatic test_mask();
      apply_reset();
      en   = 1'b1;
      mask = 5'b11011;
      for (int i = 0; i < 6; i++) begin
         step();
         $display("txn mask1 edge=%0d select=%0d valid=%0b", i, select, sel_valid);
         vectors++;
         if (select !== 3'd2 || sel_valid !== 1'b1 || forced !== 1'b0) begin
            errors++;
            $display("FAIL mask_single%0d: got sel=%0d v=%0b f=%0b, want 2/1/0",
                     i, select, sel_valid, forced);
         end
      end
      mask = 5'b11111;
      for (int i = 0; i < 3; i++) begin
         step();
         $display("txn maskall edge=%0d select=%0d valid=%0b", i, select, sel_valid);
         vectors++;
         if (select !== 3'd2 || sel_valid !== 1'b0 || forced !== 1'b0 || grant_cnt !== 16'd6) begin
            errors++;
            $display("FAIL mask_all%0d: got sel=%0d v=%0b f=%0b cnt=%0d, want 2/0/0/6",
                     i, select, sel_valid, forced, grant_cnt);
         end
      end
   endtask

   task automatic test_seed();
      logic [2:0] exp_a [4];
      logic [2:0] exp_b [4];
      logic [2:0] run1  [8];
      exp_a[0] = 3'd1; exp_a[1] = 3'd0; exp_a[2] = 3'd0; exp_a[3] = 3'd4;
      exp_b[0] = 3'd4; exp_b[1] = 3'd2; exp_b[2] = 3'd0; exp_b[3] = 3'd1;
      // Disturb the LFSR first so the zero-seed reload is observable.
      apply_reset();
      en = 1'b1;
      for (int i = 0; i < 3; i++) step();
      seed_load = 1'b1;
      seed      = 16'h0000;
      step();
      seed_load = 1'b0;
      vectors++;
      if (sel_valid !== 1'b0 || select !== 3'd0) begin
         errors++;
         $display("FAIL seed_load_edge: got sel=%0d v=%0b, want sel=0 v=0", select, sel_valid);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         $display("txn seed0 edge=%0d select=%0d valid=%0b", i, select, sel_valid);
         vectors++;
         if (select !== exp_a[i] || sel_valid !== 1'b1) begin
            errors++;
            $display("FAIL seed_zero%0d: got sel=%0d v=%0b, want sel=%0d v=1",
                     i, select, sel_valid, exp_a[i]);
         end
      end
      for (int r = 0; r < 2; r++) begin
         apply_reset();
         seed_load = 1'b1;
         seed      = 16'h1234;
         step();
         seed_load = 1'b0;
         en        = 1'b1;
         for (int i = 0; i < 8; i++) begin
            step();
            $display("txn seed1234 run=%0d edge=%0d select=%0d", r, i, select);
            if (i < 4) begin
               vectors++;
               if (select !== exp_b[i] || sel_valid !== 1'b1) begin
                  errors++;
                  $display("FAIL seed_1234_%0d: got sel=%0d v=%0b, want sel=%0d v=1",
                           i, select, sel_valid, exp_b[i]);
               end
            end
            if (r == 0) begin
               run1[i] = select;
            end else begin
               vectors++;
               if (select !== run1[i]) begin
                  errors++;
                  $display("FAIL seed_repeat%0d: got sel=%0d, want %0d", i, select, run1[i]);
               end
            end
         end
      end
   endtask

   task automatic test_starve();
      bit hit;
      int idx;
      bit seen4 = 1'b0;
      apply_reset();
      en   = 1'b1;
      mask = 5'b10000;
      for (int i = 0; i < 12; i++) begin
         exp_force(mask, hit, idx);
         step();
         vectors++;
         if (sel_valid !== 1'b1 || select === 3'd4 || forced !== hit || (hit && int'(select) != idx)) begin
            errors++;
            $display("FAIL starve_masked%0d: got sel=%0d v=%0b f=%0b, want v=1 sel!=4 f=%0b",
                     i, select, sel_valid, forced, hit);
         end
         model_update(mask);
      end
      mask = 5'b00000;
      for (int i = 0; i < 400 && !seen4; i++) begin
         exp_force(mask, hit, idx);
         step();
         vectors++;
         if (forced !== hit || (hit && int'(select) != idx)) begin
            errors++;
            $display("FAIL starve_force%0d: got sel=%0d f=%0b, want f=%0b sel=%0d",
                     i, select, forced, hit, idx);
         end
         if (forced === 1'b1 && select === 3'd4) seen4 = 1'b1;
         model_update(mask);
      end
      vectors++;
      if (!seen4) begin
         errors++;
         $display("FAIL starve_updater: got no forced grant to 4, want one within 400 edges");
      end
   endtask

   task automatic test_random();
      bit         hit;
      int         idx;
      bit         exp_valid;
      logic [4:0] m_s;
      logic [2:0] prev_sel;
      int         worst;
      apply_reset();
      for (int c = 0; c < 10000; c++) begin
         en        = ($urandom_range(0, 9) != 0);
         seed_load = ($urandom_range(0, 49) == 0);
         seed      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         for (int p = 0; p < 5; p++) mask[p] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) mask = 5'b11111;
         m_s       = mask;
         exp_valid = !seed_load && en && (mask != 5'b11111);
         exp_force(mask, hit, idx);
         prev_sel  = select;
         step();
         vectors++;
         if (sel_valid !== exp_valid) begin
            errors++;
            $display("FAIL rnd_valid c=%0d: got %0b, want %0b", c, sel_valid, exp_valid);
         end else if (exp_valid) begin
            vectors++;
            if (select >= 3'd5 || forced !== hit || (hit && int'(select) != idx) ||
                (!hit && m_s[select] !== 1'b0)) begin
               errors++;
               $display("FAIL rnd_grant c=%0d: got sel=%0d f=%0b, want f=%0b sel=%0d (if forced), unmasked",
                        c, select, forced, hit, idx);
            end
         end else begin
            vectors++;
            if (forced !== 1'b0 || select !== prev_sel) begin
               errors++;
               $display("FAIL rnd_hold c=%0d: got sel=%0d f=%0b, want sel=%0d f=0",
                        c, select, forced, prev_sel);
            end
         end
         model_update(m_s);
         // Ties among simultaneously expired processes add at most NPROC-1 grants of delay.
         worst = 0;
         for (int p = 0; p < 5; p++) if (skip[p] > worst) worst = skip[p];
         vectors++;
         if (worst > 16) begin
            errors++;
            $display("FAIL rnd_starve_bound c=%0d: got %0d grants passed over, want <= 16", c, worst);
         end
         vectors++;
         if (grant_cnt !== 16'(grants)) begin
            errors++;
            $display("FAIL rnd_grant_cnt c=%0d: got %0d, want %0d", c, grant_cnt, grants);
         end
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      en        = 1'b0;
      mask      = 5'b00000;
      seed_load = 1'b0;
      seed      = 16'h0000;
      test_reset();
      test_lfsr_sequence();
      test_async_reset();
      test_mask();
      test_seed();
      test_starve();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
